branch_predict_unit: RTL and testbench

Parametrised branch resolution and prediction unit for the rvcore datapath. It evaluates the branch condition from the raw operands, with signed and unsigned compares done internally. It also keeps a branch history table (BHT) of 2-bit saturating counters that supplies a taken/not-taken prediction to fetch, flags mispredictions on resolve, and maintains branch/mispredict statistics counters.

---
 rtl/branch_predict_unit.sv | 150 +++++++++++++++
 tb/tb_branch_predict_unit.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_predict_unit.sv
// -----------------------------------------------------------------------------
// branch_predict_unit
//
// Branch resolution and prediction for the rvcore datapath.
//   * Resolves conditional branches from the raw operands. Signed and unsigned
//     compares are done internally.
//   * Holds a branch history table (BHT) of 2-bit saturating counters. The
//     table gives fetch a taken/not-taken prediction and is trained on every
//     resolved branch.
//   * Flags mispredictions and counts resolved branches and mispredictions.
//     Both statistics counters saturate.
//
// There is no handshake. res_valid only qualifies the resolve slot, and the
// unit never stalls.
//
// Ports
//   clk, rst        clock (rising edge), asynchronous active-high reset
//   pred_pc         PC in fetch
//   pred_taken      prediction for pred_pc (combinational)
//   res_valid       resolve slot holds an instruction this cycle
//   res_pc          PC of the instruction being resolved
//   branch          [3] is-branch, [2:0] RV funct3
//   rs1, rs2        compare operands
//   res_pred_taken  prediction that fetch used for this instruction
//   bht_clear       synchronous clear of every BHT entry to INIT_STATE
//   branch_taken    resolved outcome (combinational)
//   mispredict      outcome differs from res_pred_taken (combinational)
//   br_count        resolved valid branches, saturating
//   mispred_count   mispredicted branches, saturating
// -----------------------------------------------------------------------------
module branch_predict_unit #(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned BHT_ENTRIES = 64,
    parameter logic [1:0]  INIT_STATE  = 2'b01,
    localparam int unsigned IDX_W      = $clog2(BHT_ENTRIES)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] pred_pc,
    output logic            pred_taken,
    input  logic            res_valid,
    input  logic [XLEN-1:0] res_pc,
    input  logic [3:0]      branch,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic            res_pred_taken,
    input  logic            bht_clear,
    output logic            branch_taken,
    output logic            mispredict,
    output logic [31:0]     br_count,
    output logic [31:0]     mispred_count
);

    logic [1:0]       bht_q [BHT_ENTRIES];
    logic [1:0]       bht_d;
    logic [31:0]      br_count_q;
    logic [31:0]      br_count_d;
    logic [31:0]      mispred_count_q;
    logic [31:0]      mispred_count_d;

    logic [IDX_W-1:0] pred_idx;
    logic [IDX_W-1:0] res_idx;
    logic             funct_ok;
    logic             vb;
    logic             cond;
    logic             lt_signed;
    logic             lt_unsigned;

    // Instruction alignment bits and the upper PC bits take no part in
    // indexing. They are folded here so the partial use of the PCs is explicit.
    logic             unused_pc_bits;
    assign unused_pc_bits = ^{pred_pc, res_pc};

    assign pred_idx = pred_pc[IDX_W+1:2];
    assign res_idx  = res_pc[IDX_W+1:2];

    assign lt_signed   = $signed(rs1) < $signed(rs2);
    assign lt_unsigned = rs1 < rs2;

    // The funct3 codes 010 and 011 are not conditional branches.
    assign funct_ok = (branch[2:1] != 2'b01);
    assign vb       = res_valid & branch[3] & funct_ok;

    always_comb begin
        cond = 1'b0;
        case (branch[2:0])
            3'b000:  cond = (rs1 == rs2);
            3'b001:  cond = (rs1 != rs2);
            3'b100:  cond = lt_signed;
            3'b101:  cond = ~lt_signed;
            3'b110:  cond = lt_unsigned;
            3'b111:  cond = ~lt_unsigned;
            default: cond = 1'b0;
        endcase
    end

    assign branch_taken = vb & cond;
    assign mispredict   = vb & (branch_taken ^ res_pred_taken);

    // The prediction reads the registered table, so a same-cycle update to the
    // same index only becomes visible on the next cycle.
    assign pred_taken = bht_q[pred_idx][1];

    // Next value of the trained entry, saturating at 2'b00 and 2'b11.
    always_comb begin
        bht_d = bht_q[res_idx];
        if (branch_taken) begin
            if (bht_q[res_idx] != 2'b11) bht_d = bht_q[res_idx] + 2'd1;
        end else begin
            if (bht_q[res_idx] != 2'b00) bht_d = bht_q[res_idx] - 2'd1;
        end
    end

    always_comb begin
        br_count_d      = br_count_q;
        mispred_count_d = mispred_count_q;
        if (vb && (br_count_q != 32'hFFFF_FFFF)) begin
            br_count_d = br_count_q + 32'd1;
        end
        if (mispredict && (mispred_count_q != 32'hFFFF_FFFF)) begin
            mispred_count_d = mispred_count_q + 32'd1;
        end
    end

    // A clear wins over a same-cycle training update, and the update is lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < BHT_ENTRIES; i++) bht_q[i] <= INIT_STATE;
        end else if (bht_clear) begin
            for (int i = 0; i < BHT_ENTRIES; i++) bht_q[i] <= INIT_STATE;
        end else if (vb) begin
            bht_q[res_idx] <= bht_d;
        end
    end

    // The statistics still count a branch resolved in a clear cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            br_count_q      <= 32'd0;
            mispred_count_q <= 32'd0;
        end else begin
            br_count_q      <= br_count_d;
            mispred_count_q <= mispred_count_d;
        end
    end

    assign br_count      = br_count_q;
    assign mispred_count = mispred_count_q;

endmodule

// File: tb/tb_branch_predict_unit.sv
// -----------------------------------------------------------------------------
// tb_branch_predict_unit
//
// Directed scenarios with literal expectations come first. A randomized phase
// follows. A behavioural model (an array of small integers plus two plain
// counters) predicts every output. The compare process checks the DUT against
// that model on each falling edge while reset is low.
// -----------------------------------------------------------------------------
module tb_branch_predict_unit;

  localparam int ENTRIES = 64;
  localparam int INIT    = 1;

  logic        clk;
  logic        rst;
  logic [31:0] pred_pc;
  logic        pred_taken;
  logic        res_valid;
  logic [31:0] res_pc;
  logic [3:0]  branch;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic        res_pred_taken;
  logic        bht_clear;
  logic        branch_taken;
  logic        mispredict;
  logic [31:0] br_count;
  logic [31:0] mispred_count;

  int n_total;
  int n_pass;

  // behavioural model state
  int          m_bht [ENTRIES];
  logic [31:0] m_br;
  logic [31:0] m_mis;

  branch_predict_unit #(
    .XLEN(32), .BHT_ENTRIES(ENTRIES), .INIT_STATE(2'b01)
  ) dut (
    .clk(clk), .rst(rst), .pred_pc(pred_pc), .pred_taken(pred_taken),
    .res_valid(res_valid), .res_pc(res_pc), .branch(branch), .rs1(rs1),
    .rs2(rs2), .res_pred_taken(res_pred_taken), .bht_clear(bht_clear),
    .branch_taken(branch_taken), .mispredict(mispredict),
    .br_count(br_count), .mispred_count(mispred_count)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
  endtask

  // Read an operand as a true two's-complement value in a 64-bit integer.
  function automatic longint as_signed(input logic [31:0] v);
    if (v[31]) return longint'({32'd0, v}) - 64'sd4294967296;
    return longint'({32'd0, v});
  endfunction

  function automatic bit model_vb(input logic v, input logic [3:0] br);
    int f;
    f = int'(br[2:0]);
    return v && br[3] && (f inside {0, 1, 4, 5, 6, 7});
  endfunction

  function automatic bit model_taken(input logic v, input logic [3:0] br,
                                     input logic [31:0] a, input logic [31:0] b);
    longint ua, ub;
    if (!model_vb(v, br)) return 1'b0;
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    case (int'(br[2:0]))
      0: return ua == ub;
      1: return ua != ub;
      4: return as_signed(a) < as_signed(b);
      5: return as_signed(a) >= as_signed(b);
      6: return ua < ub;
      default: return ua >= ub;
    endcase
  endfunction

  function automatic int pc_index(input logic [31:0] pc);
    return int'((pc / 4) % ENTRIES);
  endfunction

  // ---------------- model update ----------------
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) m_bht[i] = INIT;
      m_br  = 0;
      m_mis = 0;
    end else begin
      bit vb, tk;
      int idx;
      vb  = model_vb(res_valid, branch);
      tk  = model_taken(res_valid, branch, rs1, rs2);
      idx = pc_index(res_pc);
      if (vb && m_br != 32'hFFFF_FFFF) m_br = m_br + 1;
      if (vb && (tk != res_pred_taken) && m_mis != 32'hFFFF_FFFF) m_mis = m_mis + 1;
      if (bht_clear) begin
        for (int i = 0; i < ENTRIES; i++) m_bht[i] = INIT;
      end else if (vb) begin
        if (tk) m_bht[idx] = (m_bht[idx] == 3) ? 3 : m_bht[idx] + 1;
        else    m_bht[idx] = (m_bht[idx] == 0) ? 0 : m_bht[idx] - 1;
      end
    end
  end

  // ---------------- compare process (scoreboard) ----------------
  always @(negedge clk) begin
    if (!rst) begin
      bit tk;
      tk = model_taken(res_valid, branch, rs1, rs2);
      check("cmp_pred_taken", {31'd0, pred_taken}, {31'd0, m_bht[pc_index(pred_pc)] >= 2});
      check("cmp_branch_taken", {31'd0, branch_taken}, {31'd0, tk});
      check("cmp_mispredict", {31'd0, mispredict},
            {31'd0, model_vb(res_valid, branch) && (tk != res_pred_taken)});
      check("cmp_br_count", br_count, m_br);
      check("cmp_mispred_count", mispred_count, m_mis);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    res_valid = 0; res_pc = 0; branch = 0; rs1 = 0; rs2 = 0;
    res_pred_taken = 0; bht_clear = 0;
  endtask

  // Apply one resolve cycle just after the rising edge.
  task automatic resolve(input logic v, input logic [31:0] pc, input logic [3:0] br,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic pt, input logic clr);
    @(posedge clk); #1;
    res_valid = v; res_pc = pc; branch = br; rs1 = a; rs2 = b;
    res_pred_taken = pt; bht_clear = clr;
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
    idle_inputs();
  endtask

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 5))
      0: return 32'h8000_0000;
      1: return 32'h7FFF_FFFF;
      2: return 32'hFFFF_FFFF;
      3: return 32'd0;
      default: return $urandom;
    endcase
  endfunction

  // ---------------- main stimulus ----------------
  initial begin
    n_total = 0;
    n_pass  = 0;
    rst     = 1'b1;
    pred_pc = 32'h100;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_pred_taken", {31'd0, pred_taken}, 32'd0);
    check("rst_br_count", br_count, 32'd0);
    check("rst_mispred_count", mispred_count, 32'd0);

    // Counter training at 0x100: entry goes 01 -> 10 -> 11 -> 11
    for (int i = 0; i < 3; i++) begin
      resolve(1, 32'h100, 4'b1000, 32'd5, 32'd5, 0, 0);
      @(negedge clk);
      check("train_taken", {31'd0, branch_taken}, 32'd1);
      check("train_mispredict", {31'd0, mispredict}, 32'd1);
      check("train_pred", {31'd0, pred_taken}, (i == 0) ? 32'd0 : 32'd1);
    end
    idle_cycle();
    @(negedge clk);
    check("train_br_count", br_count, 32'd3);
    check("train_mispred_count", mispred_count, 32'd3);

    // Signed versus unsigned compare, resolved at 0x010 (index 4)
    resolve(1, 32'h010, 4'b1100, 32'hFFFF_FFFF, 32'd1, 0, 0);
    @(negedge clk); check("blt_neg", {31'd0, branch_taken}, 32'd1);
    resolve(1, 32'h010, 4'b1110, 32'hFFFF_FFFF, 32'd1, 0, 0);
    @(negedge clk); check("bltu_big", {31'd0, branch_taken}, 32'd0);
    resolve(1, 32'h010, 4'b1101, 32'hFFFF_FFFF, 32'd1, 0, 0);
    @(negedge clk); check("bge_neg", {31'd0, branch_taken}, 32'd0);
    resolve(1, 32'h010, 4'b1111, 32'hFFFF_FFFF, 32'd1, 0, 0);
    @(negedge clk); check("bgeu_big", {31'd0, branch_taken}, 32'd1);

    // Non-branch filtering at 0x100 (entry stays strong-taken)
    resolve(1, 32'h100, 4'b1010, 32'd9, 32'd9, 1, 0);
    @(negedge clk);
    check("nb_1010_taken", {31'd0, branch_taken}, 32'd0);
    check("nb_1010_mispredict", {31'd0, mispredict}, 32'd0);
    resolve(1, 32'h100, 4'b0000, 32'd9, 32'd9, 1, 0);
    @(negedge clk);
    check("nb_0000_taken", {31'd0, branch_taken}, 32'd0);
    check("nb_0000_mispredict", {31'd0, mispredict}, 32'd0);
    idle_cycle();
    @(negedge clk);
    check("nb_br_count", br_count, 32'd7);
    check("nb_mispred_count", mispred_count, 32'd5);
    check("nb_pred_0x100", {31'd0, pred_taken}, 32'd1);

    // Aliasing: train 0x004 taken twice; 0x104 shares index 1, 0x008 does not
    resolve(1, 32'h004, 4'b1000, 32'd7, 32'd7, 0, 0);
    resolve(1, 32'h004, 4'b1000, 32'd7, 32'd7, 0, 0);
    idle_cycle();
    pred_pc = 32'h104;
    @(negedge clk); check("alias_pred_0x104", {31'd0, pred_taken}, 32'd1);
    #1 pred_pc = 32'h008;
    #1 check("alias_pred_0x008", {31'd0, pred_taken}, 32'd0);

    // bht_clear with a same-cycle taken BNE
    resolve(1, 32'h004, 4'b1001, 32'd1, 32'd2, 1, 1);
    @(negedge clk); check("clr_bne_taken", {31'd0, branch_taken}, 32'd1);
    idle_cycle();
    pred_pc = 32'h104;
    @(negedge clk);
    check("clr_pred_0x104", {31'd0, pred_taken}, 32'd0);
    check("clr_br_count", br_count, 32'd10);
    check("clr_mispred_count", mispred_count, 32'd7);
    #1 pred_pc = 32'h100;
    #1 check("clr_pred_0x100", {31'd0, pred_taken}, 32'd0);

    // Randomized phase, checked by the compare process every cycle
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] a, b;
      a = rand_operand();
      b = ($urandom_range(0, 3) == 0) ? a : rand_operand();
      resolve($urandom_range(0, 4) != 0,
              ($urandom_range(0, 255) << 2) | $urandom_range(0, 3),
              4'($urandom_range(0, 15)), a, b,
              1'($urandom_range(0, 1)), $urandom_range(0, 60) == 0);
      pred_pc = ($urandom_range(0, 255) << 2) | $urandom_range(0, 3);
    end

    // Asynchronous reset in the middle of a cycle with a pending branch
    resolve(1, 32'h004, 4'b1000, 32'd3, 32'd3, 0, 0);
    pred_pc = 32'h004;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_br_count", br_count, 32'd0);
    check("async_mispred_count", mispred_count, 32'd0);
    check("async_pred_taken", {31'd0, pred_taken}, 32'd0);
    @(posedge clk); #1;
    idle_inputs();
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_br_count", br_count, 32'd0);
    check("post_rst_pred", {31'd0, pred_taken}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
